io_bus_arbiter: RTL and testbench

- Shares the single memory-mapped I/O peripheral bus between N_REQ independent requesters, e.g. the CPU core and a debug/loader engine.
- The bus carries 8-bit address, 8-bit write data, one-cycle w_en/r_en strobes, and registered read data valid the cycle after r_en.
- Grants use round-robin, sequence each transaction through a fixed multi-cycle FSM, and return read data with a one-cycle ack pulse.
- An optional per-requester lock keeps the grant for back-to-back transactions (e.g. scaleFactor LSB/MSB pairs).

---
 rtl/io_bus_arbiter_pkg.sv | 21 ++
 rtl/io_bus_arbiter_if.sv | 36 +++
 rtl/io_bus_arbiter_rr_pick.sv | 28 ++
 rtl/io_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_io_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the I/O bus arbiter: default widths, FSM encoding and bus timing.
package io_bus_pkg;

   localparam int unsigned N_REQ_DEF      = 2;
   localparam int unsigned ADDR_W_DEF     = 8;
   localparam int unsigned DATA_W_DEF     = 8;
   localparam int unsigned BUS_RD_LATENCY = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Index width that stays legal for a single requester.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Requester handshake plus peripheral bus; master = arbiter side, slave = requesters/peripheral.
interface io_bus_arbiter_if
   import io_bus_pkg::*;
#(
   parameter int unsigned N_REQ  = N_REQ_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
);
   localparam int unsigned ID_W = id_width(N_REQ);

   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        req_we;
   logic [N_REQ-1:0]        req_lock;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]        req_ack;
   logic [DATA_W-1:0]       req_rdata;
   logic [ID_W-1:0]         grant_id;
   logic                    busy;
   logic [ADDR_W-1:0]       bus_address;
   logic [DATA_W-1:0]       bus_din;
   logic                    bus_w_en;
   logic                    bus_r_en;
   logic [DATA_W-1:0]       bus_dout;

   modport master (
      input  req, req_we, req_lock, req_addr, req_wdata, bus_dout,
      output req_ack, req_rdata, grant_id, busy, bus_address, bus_din, bus_w_en, bus_r_en
   );

   modport slave (
      output req, req_we, req_lock, req_addr, req_wdata, bus_dout,
      input  req_ack, req_rdata, grant_id, busy, bus_address, bus_din, bus_w_en, bus_r_en
   );

endinterface

// File: rtl/io_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request searching upward from last+1, wrapping.
module rr_pick #(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          valid_c,
   output logic [IW-1:0] winner_c
);

   int unsigned idx;

   // Scan farthest-to-nearest so the nearest requester after last wins.
   always_comb begin
      valid_c  = 1'b0;
      winner_c = '0;
      idx      = 0;
      for (int unsigned k = N; k >= 1; k--) begin
         idx = (32'(last) + k) % N;
         if (req[idx]) begin
            valid_c  = 1'b1;
            winner_c = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sequencing requester transactions onto the shared I/O bus, with grant lock.
module io_bus_arbiter
   import io_bus_pkg::*;
#(
   parameter int unsigned N_REQ  = N_REQ_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input logic              clk,
   input logic              rst,
   io_bus_arbiter_if.master bus
);

   localparam int unsigned     ID_W     = id_width(N_REQ);
   localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

   state_t            state_q, state_d;
   logic [ID_W-1:0]   grant_q, grant_d, last_q, last_d;
   logic [ID_W-1:0]   pick_id_c, load_id;
   logic              pick_valid_c, load;
   logic              we_q, we_d, lock_q, lock_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d, rdata_q, rdata_d;
   logic              w_en_q, w_en_d, r_en_q, r_en_d, busy_q, busy_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   int unsigned       sel;

   rr_pick #(.N(N_REQ), .IW(ID_W)) u_pick (
      .req      (bus.req),
      .last     (last_q),
      .valid_c  (pick_valid_c),
      .winner_c (pick_id_c)
   );

   // Next state and next registered outputs; a load (arbitration or locked follow-on) enters ISSUE.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      we_d    = we_q;
      lock_d  = lock_q;
      addr_d  = addr_q;
      din_d   = din_q;
      rdata_d = rdata_q;
      w_en_d  = 1'b0;
      r_en_d  = 1'b0;
      ack_d   = '0;
      load    = 1'b0;
      load_id = pick_id_c;
      sel     = 0;

      case (state_q)
         IDLE: load = pick_valid_c;
         ISSUE: begin
            state_d        = we_q ? DONE : CAPTURE;
            ack_d[grant_q] = we_q;
         end
         CAPTURE: begin
            state_d        = DONE;
            rdata_d        = bus.bus_dout;
            ack_d[grant_q] = 1'b1;
         end
         DONE: begin
            last_d  = grant_q;
            state_d = IDLE;
            if (lock_q && bus.req[grant_q]) begin
               load    = 1'b1;
               load_id = grant_q;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         sel     = 32'(load_id);
         state_d = ISSUE;
         grant_d = load_id;
         we_d    = bus.req_we[sel];
         lock_d  = bus.req_lock[sel];
         addr_d  = bus.req_addr[sel*ADDR_W +: ADDR_W];
         din_d   = bus.req_wdata[sel*DATA_W +: DATA_W];
         w_en_d  = bus.req_we[sel];
         r_en_d  = ~bus.req_we[sel];
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LAST_RST;
         we_q    <= 1'b0;
         lock_q  <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         rdata_q <= '0;
         w_en_q  <= 1'b0;
         r_en_q  <= 1'b0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         we_q    <= we_d;
         lock_q  <= lock_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         rdata_q <= rdata_d;
         w_en_q  <= w_en_d;
         r_en_q  <= r_en_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.req_ack     = ack_q;
   assign bus.req_rdata   = rdata_q;
   assign bus.grant_id    = grant_q;
   assign bus.busy        = busy_q;
   assign bus.bus_address = addr_q;
   assign bus.bus_din     = din_q;
   assign bus.bus_w_en    = w_en_q;
   assign bus.bus_r_en    = r_en_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed scenarios plus random batches against a transaction-level model.
module tb_io_bus_arbiter;
   import io_bus_pkg::*;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   io_bus_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

   io_bus_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Peripheral: byte register file with registered read data.
   logic [DW-1:0] pmem [256];
   logic [DW-1:0] mmem [256];
   always @(posedge clk) begin
      if (bus.bus_w_en) pmem[bus.bus_address] <= bus.bus_din;
      if (bus.bus_r_en) bus.bus_dout <= pmem[bus.bus_address];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            checks = 0;
   int            errors = 0;
   int unsigned   mlast;
   logic [DW-1:0] mrdata;
   logic          b_we    [N];
   logic [AW-1:0] b_addr  [N];
   logic [DW-1:0] b_wdata [N];
   int unsigned   e_id  [64];
   int            e_stb [64];
   int            e_ack [64];
   logic [DW-1:0] e_rd  [64];

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int unsigned i);
      bus.req_we[i]               = b_we[i];
      bus.req_lock[i]             = 1'b0;
      bus.req_addr[i*AW +: AW]    = b_addr[i];
      bus.req_wdata[i*DW +: DW]   = b_wdata[i];
   endtask

   // Round-robin reference: nearest candidate after the previous owner.
   task automatic model_pick(input logic [N-1:0] cand, output int unsigned id);
      bit          found;
      int unsigned c;
      found = 1'b0;
      id    = 0;
      for (int unsigned j = 1; j <= N; j++) begin
         c = (mlast + j) % N;
         if (!found && cand[c]) begin
            id    = c;
            found = 1'b1;
         end
      end
   endtask

   // Requesters in 'who' raise req together; each drops at its ack unless held (re-request until total acks).
   task automatic run(input logic [N-1:0] who, input bit held, input int total);
      int unsigned id;
      int          t, lat, ka, ks, budget;
      logic [N-1:0] rem;
      rem = who;
      t   = cyc;
      for (int k = 0; k < total; k++) begin
         model_pick(rem, id);
         lat      = b_we[id] ? 2 : 2 + int'(BUS_RD_LATENCY);
         e_id[k]  = id;
         e_stb[k] = t + 1;
         e_ack[k] = t + lat;
         if (b_we[id]) mmem[b_addr[id]] = b_wdata[id];
         else          mrdata = mmem[b_addr[id]];
         e_rd[k] = mrdata;
         mlast   = id;
         if (!held) rem[id] = 1'b0;
         t = t + lat + 1;
      end
      for (int unsigned i = 0; i < N; i++) if (who[i]) drive(i);
      bus.req = bus.req | who;
      ka = 0;
      ks = 0;
      budget = total * 5 + 10;
      while (ka < total && budget > 0) begin
         tick();
         budget--;
         if (bus.bus_w_en || bus.bus_r_en) begin
            if (ks < total) begin
               chk("strobe_cyc", 32'(cyc), 32'(e_stb[ks]));
               chk("strobe_we", 32'(bus.bus_w_en), 32'(b_we[e_id[ks]]));
               chk("strobe_addr", 32'(bus.bus_address), 32'(b_addr[e_id[ks]]));
               chk("grant_id", 32'(bus.grant_id), e_id[ks]);
               if (b_we[e_id[ks]]) chk("strobe_din", 32'(bus.bus_din), 32'(b_wdata[e_id[ks]]));
            end else begin
               chk("extra_strobe", 32'(bus.bus_w_en | bus.bus_r_en), 32'd0);
            end
            ks++;
         end
         if (|bus.req_ack) begin
            chk("ack_vec", 32'(bus.req_ack), 32'd1 << e_id[ka]);
            chk("ack_cyc", 32'(cyc), 32'(e_ack[ka]));
            chk("ack_rdata", 32'(bus.req_rdata), 32'(e_rd[ka]));
            ka++;
            if (!held)             bus.req = bus.req & ~bus.req_ack;
            else if (ka == total)  bus.req = '0;
         end
      end
      chk("txn_timeout", 32'(ka), 32'(total));
      bus.req = '0;
      tick();
      chk("idle_after", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [N-1:0] who;
      bit           held;
      int           total;

      rst           = 1'b1;
      bus.req       = '0;
      bus.req_we    = '0;
      bus.req_lock  = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         pmem[i] = '0;
         mmem[i] = '0;
      end
      mlast  = N - 1;
      mrdata = '0;
      tick();
      tick();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_grant", 32'(bus.grant_id), 32'd0);
      chk("rst_ack", 32'(bus.req_ack), 32'd0);
      chk("rst_w_en", 32'(bus.bus_w_en), 32'd0);
      chk("rst_r_en", 32'(bus.bus_r_en), 32'd0);
      chk("rst_addr", 32'(bus.bus_address), 32'd0);
      chk("rst_din", 32'(bus.bus_din), 32'd0);
      chk("rst_rdata", 32'(bus.req_rdata), 32'd0);
      rst = 1'b0;

      // Single write, then read it back through the other requester.
      b_we[0] = 1'b1; b_addr[0] = 8'h01; b_wdata[0] = 8'hA5;
      run(3'b001, 1'b0, 1);
      chk("pmem_01", 32'(pmem[8'h01]), 32'h0000_00A5);
      b_we[1] = 1'b0; b_addr[1] = 8'h01; b_wdata[1] = 8'h00;
      run(3'b010, 1'b0, 1);

      // Single read of a preloaded register.
      pmem[8'h06] = 8'h3C;
      mmem[8'h06] = 8'h3C;
      b_we[1] = 1'b0; b_addr[1] = 8'h06;
      run(3'b010, 1'b0, 1);

      // Continuous contention: two writers, then all three requesters.
      b_we[0] = 1'b1; b_addr[0] = 8'h10; b_wdata[0] = 8'h55;
      b_we[1] = 1'b1; b_addr[1] = 8'h11; b_wdata[1] = 8'h66;
      run(3'b011, 1'b1, 4);
      b_we[2] = 1'b0; b_addr[2] = 8'h06; b_wdata[2] = 8'h00;
      run(3'b111, 1'b1, 6);

      // Locked pair from requester 1 while requester 0 waits.
      b_we[1] = 1'b1; b_addr[1] = 8'h03; b_wdata[1] = 8'h11;
      drive(1); bus.req_lock[1] = 1'b1; bus.req[1] = 1'b1;
      tick();
      chk("lk_w_en1", 32'(bus.bus_w_en), 32'd1);
      chk("lk_addr1", 32'(bus.bus_address), 32'h03);
      chk("lk_grant1", 32'(bus.grant_id), 32'd1);
      b_we[0] = 1'b1; b_addr[0] = 8'h05; b_wdata[0] = 8'h22;
      drive(0); bus.req[0] = 1'b1;
      tick();
      chk("lk_ack1", 32'(bus.req_ack), 32'b010);
      chk("lk_noen1", 32'(bus.bus_w_en), 32'd0);
      b_addr[1] = 8'h04; b_wdata[1] = 8'h33;
      drive(1);
      tick();
      chk("lk_w_en2", 32'(bus.bus_w_en), 32'd1);
      chk("lk_addr2", 32'(bus.bus_address), 32'h04);
      chk("lk_din2", 32'(bus.bus_din), 32'h33);
      chk("lk_grant2", 32'(bus.grant_id), 32'd1);
      tick();
      chk("lk_ack2", 32'(bus.req_ack), 32'b010);
      bus.req[1] = 1'b0;
      tick();
      chk("lk_idle", 32'(bus.busy), 32'd0);
      chk("lk_idle_en", 32'(bus.bus_w_en), 32'd0);
      tick();
      chk("lk_grant0", 32'(bus.grant_id), 32'd0);
      chk("lk_addr0", 32'(bus.bus_address), 32'h05);
      chk("lk_w_en0", 32'(bus.bus_w_en), 32'd1);
      tick();
      chk("lk_ack0", 32'(bus.req_ack), 32'b001);
      bus.req[0] = 1'b0;
      tick();
      chk("lk_end_busy", 32'(bus.busy), 32'd0);
      mmem[8'h03] = 8'h11; mmem[8'h04] = 8'h33; mmem[8'h05] = 8'h22;
      mlast = 0;

      // Requester 0 withdraws before it can be latched.
      b_we[1] = 1'b1; b_addr[1] = 8'h07; b_wdata[1] = 8'h44;
      drive(1); bus.req[1] = 1'b1;
      tick();
      chk("wd_w_en", 32'(bus.bus_w_en), 32'd1);
      b_we[0] = 1'b0; b_addr[0] = 8'h00;
      drive(0); bus.req[0] = 1'b1;
      tick();
      chk("wd_ack1", 32'(bus.req_ack), 32'b010);
      bus.req = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wd_busy", 32'(bus.busy), 32'd0);
         chk("wd_strobe", 32'(bus.bus_w_en | bus.bus_r_en), 32'd0);
         chk("wd_grant", 32'(bus.grant_id), 32'd1);
         chk("wd_ack", 32'(bus.req_ack), 32'd0);
      end
      mmem[8'h07] = 8'h44;
      mlast = 1;

      // Reset during CAPTURE of a read aborts it without an ack.
      b_we[0] = 1'b0; b_addr[0] = 8'h06;
      drive(0); bus.req[0] = 1'b1;
      tick();
      chk("rs_r_en", 32'(bus.bus_r_en), 32'd1);
      tick();
      chk("rs_busy_cap", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req[0] = 1'b0;
      chk("rs_busy", 32'(bus.busy), 32'd0);
      chk("rs_w_en", 32'(bus.bus_w_en), 32'd0);
      chk("rs_r_en0", 32'(bus.bus_r_en), 32'd0);
      chk("rs_ack", 32'(bus.req_ack), 32'd0);
      chk("rs_rdata", 32'(bus.req_rdata), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rs_no_ack", 32'(bus.req_ack), 32'd0);
      end
      mlast  = N - 1;
      mrdata = '0;
      run(3'b001, 1'b0, 1);

      // Random contention batches.
      for (int r = 0; r < 25; r++) begin
         who = N'($urandom_range(1, (1 << N) - 1));
         for (int unsigned i = 0; i < N; i++) begin
            b_we[i]    = 1'($urandom_range(0, 1));
            b_addr[i]  = AW'($urandom_range(0, 15));
            b_wdata[i] = DW'($urandom);
         end
         held  = 1'($urandom_range(0, 1));
         total = held ? 2 * $countones(who) : $countones(who);
         run(who, held, total);
      end
      for (int a = 0; a < 16; a++) chk("pmem_final", 32'(pmem[a]), 32'(mmem[a]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
